// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: time-multiplexes DIGITS BCD digits onto one shared
// registered 7-segment decoder. Each digit slot starts with an all-off
// blanking window, leading zeros can be suppressed, and new digit values
// only reach the displayed (shadow) register on a frame boundary.
//
// Handshake: load is a single-cycle strobe with no back-pressure; every
// load is accepted into the pending register (latest wins). load_ack is a
// single-cycle pulse, asserted combinationally in the cycle whose rising
// edge copies a value into the shadow register.
module digit_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16,
  parameter int LZ_BLANK  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic                  load,
  output logic                  load_ack,
  output logic [3:0]            number,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_done,
  output logic [1:0]            dbg_state
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  state_t              r_state, w_state_next;
  logic [CW-1:0]       r_cnt, w_cnt_next;
  logic [IW-1:0]       r_idx, w_idx_next;
  logic [4*DIGITS-1:0] r_pending;
  logic [4*DIGITS-1:0] r_shadow, w_shadow_next;
  logic                r_pend_flag, w_pend_flag_next;
  logic [3:0]          r_number, w_number_next;
  logic [DIGITS-1:0]   r_digit_sel, w_sel_next;
  logic                w_wrap;
  logic                w_commit;
  logic                w_ack;

  // A digit above position 0 is dark when it and every more significant
  // digit are zero; codes 10..15 count as nonzero.
  function automatic logic f_blanked(input logic [4*DIGITS-1:0] sh,
                                     input logic [IW-1:0] k);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= int'(k) && sh[4*j +: 4] != 4'h0) upper_zero = 1'b0;
    end
    return (LZ_BLANK != 0) && (k != '0) && upper_zero;
  endfunction

  function automatic logic [3:0] f_digit(input logic [4*DIGITS-1:0] sh,
                                         input logic [IW-1:0] k);
    return sh[4*int'(k) +: 4];
  endfunction

  // Next-state, slot counters, shadow commit and decoder/enable values.
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_idx_next       = r_idx;
    w_wrap           = 1'b0;
    w_commit         = 1'b0;
    w_shadow_next    = r_shadow;
    w_pend_flag_next = r_pend_flag;
    w_ack            = 1'b0;

    if (!en) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
      w_idx_next   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_next = S_BLANK;
          w_cnt_next   = '0;
          w_idx_next   = '0;
          w_commit     = 1'b1;
        end
        S_BLANK: begin
          w_cnt_next = r_cnt + 1'b1;
          if (r_cnt == BLK_LAST) w_state_next = S_SHOW;
        end
        S_SHOW: begin
          if (r_cnt == CNT_LAST) begin
            w_cnt_next   = '0;
            w_state_next = S_BLANK;
            if (r_idx == IDX_LAST) begin
              w_idx_next = '0;
              w_wrap     = 1'b1;
              w_commit   = 1'b1;
            end else begin
              w_idx_next = r_idx + 1'b1;
            end
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
          w_idx_next   = '0;
        end
      endcase
    end

    // A load landing on a commit point bypasses pending entirely.
    if (w_commit && load) begin
      w_shadow_next    = digits_in;
      w_pend_flag_next = 1'b0;
      w_ack            = 1'b1;
    end else if (w_commit && r_pend_flag) begin
      w_shadow_next    = r_pending;
      w_pend_flag_next = 1'b0;
      w_ack            = 1'b1;
    end else if (load) begin
      w_pend_flag_next = 1'b1;
    end

    // number follows the state being entered; digit_sel follows the state
    // being left, which lines it up with the decoder's extra register stage.
    if (w_state_next == S_SHOW && !f_blanked(w_shadow_next, w_idx_next))
      w_number_next = f_digit(w_shadow_next, w_idx_next);
    else
      w_number_next = 4'hF;

    if (r_state == S_SHOW && !f_blanked(r_shadow, r_idx))
      w_sel_next = ~(DIGITS'(1) << r_idx);
    else
      w_sel_next = '1;
  end

  // Scan FSM state and slot/digit counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
    end
  end

  // Pending/shadow digit storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending   <= '0;
      r_pend_flag <= 1'b0;
      r_shadow    <= '0;
    end else begin
      if (load) r_pending <= digits_in;
      r_pend_flag <= w_pend_flag_next;
      r_shadow    <= w_shadow_next;
    end
  end

  // Registered decoder input and digit enables.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_number    <= 4'hF;
      r_digit_sel <= '1;
    end else begin
      r_number    <= w_number_next;
      r_digit_sel <= w_sel_next;
    end
  end

  assign number     = r_number;
  assign digit_sel  = r_digit_sel;
  assign load_ack   = w_ack & ~rst;
  assign frame_done = w_wrap & ~rst;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl: directed steps then random traffic, checked
// against a frame-position model of the scan (slot = pos/SCAN_DIV).
module tb_digit_scan_ctrl;

  localparam int D  = 4;
  localparam int S  = 8;
  localparam int B  = 2;
  localparam int FR = D * S;

  // Clock / reset block
  logic clk = 1'b0;
  logic rst, en, load;
  logic [4*D-1:0] digits_in;
  logic load_ack, frame_done, load_ack_n, frame_done_n;
  logic [3:0] number, number_n;
  logic [D-1:0] digit_sel, digit_sel_n;
  logic [1:0] dbg_state, dbg_state_n;

  always #5 clk = ~clk;

  digit_scan_ctrl #(.DIGITS(D), .SCAN_DIV(S), .BLANK_CYC(B), .LZ_BLANK(1)) dut (
    .clk(clk), .rst(rst), .en(en), .digits_in(digits_in), .load(load),
    .load_ack(load_ack), .number(number), .digit_sel(digit_sel),
    .frame_done(frame_done), .dbg_state(dbg_state)
  );

  digit_scan_ctrl #(.DIGITS(D), .SCAN_DIV(S), .BLANK_CYC(B), .LZ_BLANK(0)) dut_nolz (
    .clk(clk), .rst(rst), .en(en), .digits_in(digits_in), .load(load),
    .load_ack(load_ack_n), .number(number_n), .digit_sel(digit_sel_n),
    .frame_done(frame_done_n), .dbg_state(dbg_state_n)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: scan position within the frame plus load bookkeeping
  bit          m_on;
  int          m_pos;
  logic [15:0] m_shadow, m_pending;
  bit          m_pflag;
  logic [3:0]  m_sel_q, m_sel_q_n;

  function automatic bit lit(input bit lz);
    int slot;
    int off;
    slot = m_pos / S;
    off  = m_pos % S;
    if (!m_on || off < B) return 1'b0;
    if (lz && slot > 0 && (m_shadow >> (4 * slot)) == 16'h0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] exp_num(input bit lz);
    int slot;
    slot = m_pos / S;
    if (!lit(lz)) return 4'hF;
    return m_shadow[4*slot +: 4];
  endfunction

  function automatic logic [3:0] exp_sel(input bit lz);
    logic [3:0] one;
    one = 4'b0001;
    if (!lit(lz)) return 4'hF;
    return ~(one << (m_pos / S));
  endfunction

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Driver: one clock cycle with given inputs, checks, then model advance
  task automatic tick(input logic e, input logic ld, input logic [15:0] d);
    bit commit;
    en = e; load = ld; digits_in = d;
    @(negedge clk);
    commit = e && (!m_on || m_pos == FR - 1);
    chk("number",         number,      exp_num(1'b1));
    chk("digit_sel",      digit_sel,   m_sel_q);
    chk("number_nolz",    number_n,    exp_num(1'b0));
    chk("digit_sel_nolz", digit_sel_n, m_sel_q_n);
    chk("load_ack",       load_ack,    commit && (ld || m_pflag));
    chk("frame_done",     frame_done,  e && m_on && m_pos == FR - 1);
    chk("one_low_max",    ($countones(~digit_sel) <= 1), 1'b1);
    m_sel_q   = exp_sel(1'b1);
    m_sel_q_n = exp_sel(1'b0);
    if (commit && ld) begin
      m_shadow = d; m_pflag = 1'b0;
    end else if (commit && m_pflag) begin
      m_shadow = m_pending; m_pflag = 1'b0;
    end else if (ld) begin
      m_pflag = 1'b1;
    end
    if (ld) m_pending = d;
    if (!e) begin
      m_on = 1'b0; m_pos = 0;
    end else if (!m_on) begin
      m_on = 1'b1; m_pos = 0;
    end else begin
      m_pos = (m_pos + 1) % FR;
    end
    @(posedge clk); #1;
  endtask

  // Async reset mid-cycle; outputs must go dark before any clock edge
  task automatic do_reset();
    en = 1'b0; load = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_number",    number,     4'hF);
    chk("rst_digit_sel", digit_sel,  4'hF);
    chk("rst_load_ack",  load_ack,   1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    m_on = 1'b0; m_pos = 0; m_shadow = '0; m_pending = '0; m_pflag = 1'b0;
    m_sel_q = 4'hF; m_sel_q_n = 4'hF;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Run scanning until the model reaches a given frame position (bounded)
  task automatic advance_to(input int target);
    int guard;
    guard = 0;
    while (!(m_on && m_pos == target) && guard < 2 * FR) begin
      tick(1'b1, 1'b0, 16'h0);
      guard++;
    end
    chk("advance_reached", (m_on && m_pos == target), 1'b1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; digits_in = '0;
    @(posedge clk); #1;
    do_reset();
    repeat (3) tick(1'b0, 1'b0, 16'h0);

    // Load while disabled, then enable: ack on the rise, scan 1234
    tick(1'b0, 1'b1, 16'h1234);
    tick(1'b0, 1'b0, 16'h0);
    repeat (2 * FR + 1) tick(1'b1, 1'b0, 16'h0);

    // Reset in the middle of a SHOW window, then stay dark with en=0
    advance_to(12);
    do_reset();
    repeat (4) tick(1'b0, 1'b0, 16'h0);

    // Leading-zero patterns
    tick(1'b1, 1'b1, 16'h0050);
    repeat (2 * FR) tick(1'b1, 1'b0, 16'h0);
    advance_to(5);
    tick(1'b1, 1'b1, 16'h0000);
    repeat (2 * FR) tick(1'b1, 1'b0, 16'h0);

    // Two loads inside one frame: latest wins, committed at the boundary
    advance_to(10);
    tick(1'b1, 1'b1, 16'h1111);
    repeat (5) tick(1'b1, 1'b0, 16'h0);
    tick(1'b1, 1'b1, 16'h2222);
    repeat (FR + 4) tick(1'b1, 1'b0, 16'h0);

    // Load exactly on the boundary cycle
    advance_to(FR - 1);
    tick(1'b1, 1'b1, 16'h5678);
    repeat (FR) tick(1'b1, 1'b0, 16'h0);

    // Drop en mid-slot with a load pending, then re-enable
    advance_to(19);
    tick(1'b0, 1'b1, 16'h9876);
    repeat (2) tick(1'b0, 1'b0, 16'h0);
    repeat (FR + 5) tick(1'b1, 1'b0, 16'h0);

    // Random traffic
    for (int i = 0; i < 1000; i++) begin
      logic        e, ld;
      logic [15:0] d;
      e  = ($urandom_range(0, 49) != 0);
      ld = ($urandom_range(0, 15) == 0);
      d  = 16'($urandom) >> (4 * $urandom_range(0, 4));
      tick(e, ld, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
